uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

- Serial receive half of the UART: recovers 8N1 frames (8E1 with parity) from the `rx` line using 16x oversampling.
- Buffers received bytes in a first-word-fall-through FIFO, which the host drains with `rd_uart`.
- Sits opposite the transmitter on the serial link and exposes the same `rx_dout` / `rx_fifo_*` status set as the top-level UART.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame and FIFO word width.
- `FIFO_DEPTH`, default 16: FIFO entries. Must be a power of two, ≥2.
- `BAUD_DIV`, default 27: clocks per oversample tick. One bit period is 16·BAUD_DIV clocks. Must be ≥2.
- `clk`  input  1  sole clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line, idle high; asynchronous to `clk`.
- `rd_uart`  input  1  pop strobe; one word per cycle while asserted.
- `rx_dout`  output  DATA_WIDTH  FIFO head word; meaningful only when `rx_fifo_empty`=0.
- `rx_fifo_cnt`  output  $clog2(FIFO_DEPTH)+1  number of stored words, 0..FIFO_DEPTH.
- `rx_fifo_empty`  output  1  count == 0.
- `rx_fifo_full`  output  1  count == FIFO_DEPTH.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  output  1  one-cycle pulse: good frame dropped because FIFO was full.
- `parity_err`  output  1  one-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.

## Operation
- **Reset values:**
  - `rx_dout`=0, `rx_fifo_cnt`=0, `rx_fifo_empty`=1, `rx_fifo_full`=0.
  - All error pulses 0; FSM in IDLE.
  - Synchronizer flops reset to 1; `armed`=0.
  - FIFO storage is reset to 0.
- **Input sync:** 2-flop synchronizer on `rx`; all FSM decisions use the synchronized value `rxs`.
- **Tick generator:**
  - Counter runs 0..BAUD_DIV-1, free-running from reset.
  - `tick` is high for one clock when counter == BAUD_DIV-1.
  - Sample counter `s` (4 bit) advances only on `tick`.
- **Arming:** after reset the FSM ignores `rxs` until it has sampled `rxs`=1 on a tick, which sets `armed`. This prevents a false start when reset is released mid-frame.
- **FSM:**
  - **IDLE:** if `armed` and `rxs`=0, go to START with `s`=0.
  - **START:** on the tick where `s`==7 (mid start bit), go to DATA if `rxs`=0, otherwise back to IDLE (glitch rejected). Clear `s`.
  - **DATA:** on the tick where `s`==15, shift `rxs` in LSB-first and increment bit count `n`. After DATA_WIDTH bits, go to PARITY (if compiled in) or STOP.
  - **PARITY:** on `s`==15, compare `rxs` with the even parity of the data; latch the mismatch. Go to STOP.
  - **STOP:** on `s`==15, go to IDLE and resolve the frame:
    - `rxs`=0: pulse `frame_err`, discard the byte.
    - `rxs`=1 with parity mismatch: pulse `parity_err`, discard the byte.
    - Otherwise, push the byte.
- **FIFO:**
  - Circular buffer; pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - `rx_dout` = mem[rd_ptr].
  - Push while full: when not popping in the same cycle, drop the byte and pulse `overrun_err`.
  - Pop while empty: ignored; count stays 0.
  - Push + pop same cycle while full: both occur, count unchanged, no overrun.
  - Push + pop same cycle while empty: push only.
  - Push + pop in any other state: both occur, count unchanged.

## Timing
- Push happens on the clock carrying the STOP `s`==15 tick. The word becomes visible on `rx_dout`, `rx_fifo_empty` deasserts, and `rx_fifo_cnt` increments on the next edge.
- Error pulses assert on the same edge a push would have occurred.
- Pop with `rd_uart` high: `rx_dout` shows the next word and the count decrements after that edge.
- Frame latency from the falling edge of the start bit to push is ≈ (16·(DATA_WIDTH+1)+8)·BAUD_DIV + 2 clocks, ±BAUD_DIV jitter from tick phase.
- Back-to-back frames: the FSM re-enters IDLE at the mid-stop sample and accepts a start edge immediately after.
- Asserting `rst` mid-frame: partial frame discarded, FIFO emptied, outputs return to reset values at once.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is start + DATA_WIDTH data + even parity + stop.
  - The PARITY state exists and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined:
  - Frame is start + data + stop.
  - The PARITY state and parity logic are absent; `parity_err` is constant 0.

## Test plan
- Reset, `rx` held high, BAUD_DIV=4: send 0xA5 8N1 → after ≈600 clk `rx_dout`=0xA5, `rx_fifo_cnt`=1, `rx_fifo_empty`=0.
- Pulse `rx` low for 3·BAUD_DIV clocks, then high → no push, FSM back in IDLE, count stays 0.
- Send 0x3C with the stop bit driven low → one-cycle `frame_err`, count unchanged.
- Send 17 bytes 0x00..0x10 with no reads (FIFO_DEPTH=16) → `rx_fifo_full`=1, `overrun_err` pulses once, `rx_dout`=0x00. Pop 16 times → bytes 0x00..0x0F in order, then `rx_fifo_empty`=1.
- FIFO full, assert `rd_uart` on the push cycle of a 17th byte 0x55 → no overrun, count remains 16, 0x55 is read last.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `parity_err` pulse, no push. Resend with parity bit 1 → push of 0x07.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : UART receive path. A 2-flop synchronizer feeds a
//                16x-oversampling frame recovery FSM; good bytes are pushed
//                into a first-word-fall-through FIFO that the host drains
//                with rd_uart.
//  Ports       : clk           - sole clock, rising edge
//                rst           - asynchronous reset, active low
//                rx            - serial line, idle high, asynchronous
//                rd_uart       - pop strobe, one word per asserted cycle
//                rx_dout       - FIFO head word (valid when not empty)
//                rx_fifo_cnt   - stored word count, 0..FIFO_DEPTH
//                rx_fifo_empty - count == 0
//                rx_fifo_full  - count == FIFO_DEPTH
//                frame_err     - 1-cycle pulse, stop bit sampled low
//                overrun_err   - 1-cycle pulse, good frame dropped (full)
//                parity_err    - 1-cycle pulse, even-parity mismatch
//  Options     : UART_RX_PARITY_EN - adds an even parity bit after the data
//                bits; when undefined parity_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_DIV   = 27
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_uart,
    output logic [DATA_WIDTH-1:0]         rx_dout,
    output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_cnt,
    output logic                          rx_fifo_empty,
    output logic                          rx_fifo_full,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          parity_err
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_BW = $clog2(BAUD_DIV);
    localparam int c_NW = $clog2(DATA_WIDTH + 1);

    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(BAUD_DIV - 1);
    localparam logic [c_NW-1:0] c_N_LAST    = c_NW'(DATA_WIDTH - 1);
    localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer (idle-high reset so no false edge at release)
    // ------------------------------------------------------------------
    logic r_sync1, r_sync2;
    logic w_rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    logic [c_BW-1:0] r_baud;
    logic            w_tick;

    assign w_tick = (r_baud == c_BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_baud <= '0;
        else if (w_tick) r_baud <= '0;
        else             r_baud <= r_baud + 1'b1;
    end

    // ------------------------------------------------------------------
    // Frame recovery FSM
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [3:0]            r_s;
    logic [c_NW-1:0]       r_n;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_armed;
    logic                  r_frame_err;
    logic                  w_push;
`ifdef UART_RX_PARITY_EN
    logic                  r_par_bad;
    logic                  r_par_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_s         <= 4'd0;
            r_n         <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad   <= 1'b0;
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
            // A line seen idle on a tick proves we are between frames.
            if (w_tick && w_rxs)
                r_armed <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (r_armed && !w_rxs) begin
                        r_state <= ST_START;
                        r_s     <= 4'd0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_s == 4'd7) begin
                            r_s     <= 4'd0;
                            r_n     <= '0;
                            r_state <= w_rxs ? ST_IDLE : ST_DATA;
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_s <= r_s + 4'd1;   // wraps 15 -> 0 at each bit centre
                        if (r_s == 4'hF) begin
                            r_shift <= {w_rxs, r_shift[DATA_WIDTH-1:1]};
                            r_n     <= r_n + 1'b1;
                            if (r_n == c_N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_s <= r_s + 4'd1;
                        if (r_s == 4'hF) begin
                            r_par_bad <= w_rxs ^ (^r_shift);
                            r_state   <= ST_STOP;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick) begin
                        r_s <= r_s + 4'd1;
                        if (r_s == 4'hF) begin
                            r_state <= ST_IDLE;
                            if (!w_rxs)
                                r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            else if (r_par_bad)
                                r_par_err <= 1'b1;
`endif
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_push = (r_state == ST_STOP) && w_tick && (r_s == 4'hF) && w_rxs
`ifdef UART_RX_PARITY_EN
                    && !r_par_bad
`endif
                    ;

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0]       r_cnt;
    logic                  r_ovr;
    logic                  w_pop, w_full, w_wr;

    assign w_full = (r_cnt == c_DEPTH);
    assign w_pop  = rd_uart && (r_cnt != '0);
    // When full, a simultaneous pop frees the slot being overwritten.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovr    <= 1'b0;
        end else begin
            r_ovr <= w_push && w_full && !w_pop;
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rx_dout       = r_mem[r_rd_ptr];
    assign rx_fifo_cnt   = r_cnt;
    assign rx_fifo_empty = (r_cnt == '0);
    assign rx_fifo_full  = w_full;
    assign frame_err     = r_frame_err;
    assign overrun_err   = r_ovr;
`ifdef UART_RX_PARITY_EN
    assign parity_err    = r_par_err;
`else
    assign parity_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Randomized scoreboard bench for uart_rx_fifo. The driver
//                serializes frames and records the expected outcome (stored
//                byte or error event) in queues; a negedge monitor checks
//                every pop and every error pulse against those queues.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int BDIV  = 4;
    localparam int BIT   = 16 * BDIV;

    localparam logic [7:0] EV_F = 8'h46;
    localparam logic [7:0] EV_O = 8'h4F;
    localparam logic [7:0] EV_P = 8'h50;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx = 1'b1;
    logic          rd_uart = 1'b0;
    logic [DW-1:0] rx_dout;
    logic [4:0]    rx_fifo_cnt;
    logic          rx_fifo_empty, rx_fifo_full;
    logic          frame_err, overrun_err, parity_err;

    uart_rx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BAUD_DIV(BDIV)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_uart(rd_uart),
        .rx_dout(rx_dout), .rx_fifo_cnt(rx_fifo_cnt),
        .rx_fifo_empty(rx_fifo_empty), .rx_fifo_full(rx_fifo_full),
        .frame_err(frame_err), .overrun_err(overrun_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    logic [7:0] exp_q[$];   // reference FIFO contents
    logic [7:0] ev_q[$];    // expected error pulses in order
    int n_checks = 0;
    int n_fail   = 0;
    int K, X, E;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_event(input string name, input logic [7:0] code);
        if (ev_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got unexpected pulse expected none at %0t", name, $time);
        end else begin
            check(name, code, ev_q.pop_front());
        end
    endtask

    // Monitor: error pulses and pops compared against the reference queues.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err)   mon_event("frame_err", EV_F);
            if (overrun_err) mon_event("overrun_err", EV_O);
            if (parity_err)  mon_event("parity_err", EV_P);
            if (rd_uart) begin
                if (exp_q.size() == 0) begin
                    check("pop_empty_flag", rx_fifo_empty, 1);
                end else begin
                    check("pop_empty_flag", rx_fifo_empty, 0);
                    check("pop_data", rx_dout, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tw(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par);
        rx = 1'b0; tw(BIT);
        for (int i = 0; i < DW; i++) begin
            rx = d[i]; tw(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ bad_par; tw(BIT);
`endif
        if (bad_stop) begin
            // Low through the sample point, then idle long enough for the
            // resulting false start to be rejected.
            rx = 1'b0; tw(12 * BDIV);
            rx = 1'b1; tw(4 * BDIV + 2 * BIT);
        end else begin
            rx = 1'b1; tw(BIT);
        end
    endtask

    // Reference model: decide the fate of a frame from the frame rules.
    task automatic send_byte(input logic [7:0] d, input bit bad_stop, input bit bad_par,
                             input bit popping);
        bit par_fail;
        par_fail = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_fail = bad_par;
`endif
        if (bad_stop)                                   ev_q.push_back(EV_F);
        else if (par_fail)                              ev_q.push_back(EV_P);
        else if (exp_q.size() >= DEPTH && !popping)     ev_q.push_back(EV_O);
        else                                            exp_q.push_back(d);
        send_frame(d, bad_stop, bad_par);
    endtask

    task automatic pop_n(input int n);
        rd_uart = 1'b1; tw(n);
        rd_uart = 1'b0; tw(1);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cnt"},   rx_fifo_cnt, exp_q.size());
        check({tag, "_empty"}, rx_fifo_empty, exp_q.size() == 0);
        check({tag, "_full"},  rx_fifo_full, exp_q.size() == DEPTH);
        if (exp_q.size() > 0)
            check({tag, "_head"}, rx_dout, exp_q[0]);
    endtask

    task automatic align();
        do tw(1); while (cyc % BDIV != 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        K = 0;
        // ---------------- reset values ----------------
        tw(3);
        check("rst_dout", rx_dout, 0);
        check("rst_cnt", rx_fifo_cnt, 0);
        check("rst_empty", rx_fifo_empty, 1);
        check("rst_full", rx_fifo_full, 0);
        check("rst_errs", {frame_err, overrun_err, parity_err}, 0);
        rst = 1'b1;
        tw(2 * BIT);

        // ---------------- first frame, latency calibration ----------------
        align();
        X = cyc;
        E = -1;
        fork
            send_byte(8'hA5, 0, 0, 0);
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (rx_fifo_cnt != 0) begin
                        E = cyc;
                        break;
                    end
                end
            end
        join
        check("first_push_seen", E >= 0, 1);
        K = E - X;
        check("first_latency_window", (K >= 600 && K <= 625), 1);
        check_state("a5");
        pop_n(1);
        check_state("a5_drained");

        // ---------------- start-bit glitch ----------------
        rx = 1'b0; tw(3 * BDIV);
        rx = 1'b1; tw(3 * BIT);
        check_state("glitch");

        // ---------------- frame error ----------------
        send_byte(8'h3C, 1, 0, 0);
        check_state("frame_err");

        // ---------------- randomized traffic ----------------
        for (int f = 0; f < 16; f++) begin
            d = 8'($urandom);
            send_byte(d, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 0);
            tw($urandom_range(1, 40));
            if ($urandom_range(0, 2) == 0)
                pop_n(exp_q.size() > 0 ? $urandom_range(1, exp_q.size()) : 1);
            check_state("rand");
        end
        if (exp_q.size() > 0) pop_n(exp_q.size());
        check_state("rand_drained");

        // ---------------- overrun ----------------
        for (int i = 0; i <= DEPTH; i++) begin
            send_byte(8'(i), 0, 0, 0);
            tw($urandom_range(0, 8));
        end
        check_state("overrun_full");
        pop_n(DEPTH);
        check_state("overrun_drained");

        // ---------------- push + pop while full ----------------
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 0, 0, 0);
        check_state("refill");
        align();
        X = cyc;
        fork
            send_byte(8'h55, 0, 0, 1);
            begin
                for (int i = 0; i < 2000; i++) begin
                    tw(1);
                    if (cyc == X + K - 1) break;
                end
                rd_uart = 1'b1; tw(1);
                rd_uart = 1'b0;
            end
        join
        tw(4);
        check_state("push_pop_full");
        pop_n(DEPTH);
        check_state("push_pop_drained");

`ifdef UART_RX_PARITY_EN
        // ---------------- parity ----------------
        send_byte(8'h07, 0, 1, 0);
        check_state("par_bad");
        send_byte(8'h07, 0, 0, 0);
        check_state("par_good");
        pop_n(1);
`endif

        // ---------------- mid-frame reset and arming ----------------
        send_byte(8'($urandom), 0, 0, 0);
        check_state("pre_reset");
        rx = 1'b0; tw(3 * BIT);
        rst = 1'b0; #1;
        check("mid_rst_cnt", rx_fifo_cnt, 0);
        check("mid_rst_empty", rx_fifo_empty, 1);
        check("mid_rst_dout", rx_dout, 0);
        check("mid_rst_full", rx_fifo_full, 0);
        exp_q.delete();
        ev_q.delete();
        tw(3);
        rst = 1'b1;
        tw(2 * BIT);
        rx = 1'b1;
        tw(14 * BIT);
        check_state("armed_ignore");
        send_byte(8'($urandom), 0, 0, 0);
        tw(10);
        check_state("post_reset");
        pop_n(1);
        check_state("post_reset_drained");

        tw(20);
        check("events_pending", ev_q.size(), 0);
        check("model_pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
